// File: rtl/logic_gate_pkg.sv
// Shared op-code definitions for the N-channel bitwise logic unit and its
// combinational core.
package logic_gate_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND     = 3'd0;
    localparam logic [OP_W-1:0] OP_OR      = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR     = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND    = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR     = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR    = 3'd5;
    localparam logic [OP_W-1:0] OP_PASS    = 3'd6;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op != OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/logic_gate_core.sv
// Combinational CHANNELS-wide bitwise reduction; inverted ops invert the full
// reduction. Illegal op codes give a zero result with err set.
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]           op,
    output logic [WIDTH-1:0]          result,
    output logic                      err
);

    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;

    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            and_r = and_r & in_data[k*WIDTH +: WIDTH];
            or_r  = or_r  | in_data[k*WIDTH +: WIDTH];
            xor_r = xor_r ^ in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        result = '0;
        err    = !op_is_legal(op);
        case (op)
            OP_AND:  result = and_r;
            OP_OR:   result = or_r;
            OP_XOR:  result = xor_r;
            OP_NAND: result = ~and_r;
            OP_NOR:  result = ~or_r;
            OP_XNOR: result = ~xor_r;
            OP_PASS: result = in_data[WIDTH-1:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipelined logic unit with wrapping transaction counter.
// Optional out_parity port enabled by defining LOGIC_GATE_PIPE_PARITY_EN.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]           in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [OP_W-1:0]           out_op,
    output logic                      out_err,
    output logic [CNT_W-1:0]          txn_count
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    ,
    output logic                      out_parity
`endif
);

    logic                      vld_p1;
    logic [CHANNELS*WIDTH-1:0] data_p1;
    logic [OP_W-1:0]           op_p1;

    logic                      vld_p2;
    logic [WIDTH-1:0]          data_p2;
    logic [OP_W-1:0]           op_p2;
    logic                      err_p2;

    logic [WIDTH-1:0]          res_c;
    logic                      err_c;

    logic                      s2_free;
    logic                      s1_adv;
    logic                      in_fire;
    logic                      out_fire;
    logic [CNT_W-1:0]          cnt;

    // Ready depends only on pipeline state and out_ready, never on in_valid.
    assign s2_free  = !vld_p2 || out_ready;
    assign s1_adv   = vld_p1 && s2_free;
    assign in_ready = !vld_p1 || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld_p2 && out_ready;

    // Stage 1: capture input word on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_fire) begin
            vld_p1 <= 1'b1;
        end else if (s1_adv) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            data_p1 <= in_data;
            op_p1   <= in_op;
        end
    end

    logic_gate_core #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_core (
        .in_data (data_p1),
        .op      (op_p1),
        .result  (res_c),
        .err     (err_c)
    );

    // Stage 2: registered result; holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            op_p2   <= '0;
            err_p2  <= 1'b0;
        end else if (s2_free) begin
            vld_p2 <= vld_p1;
            if (s1_adv) begin
                data_p2 <= res_c;
                op_p2   <= op_p1;
                err_p2  <= err_c;
            end
        end
    end

`ifdef LOGIC_GATE_PIPE_PARITY_EN
    logic parity_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_p2 <= 1'b0;
        end else if (s1_adv) begin
            parity_p2 <= ^res_c;
        end
    end

    assign out_parity = parity_p2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_fire) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_op    = op_p2;
    assign out_err   = err_p2;
    assign txn_count = cnt;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed self-checking bench for logic_gate_pipe (WIDTH=8, CHANNELS=4).
// Parity checks are included when LOGIC_GATE_PIPE_PARITY_EN is defined.
module tb_logic_gate_pipe;
    import logic_gate_pkg::*;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CNT_W    = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [OP_W-1:0]           in_op;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [OP_W-1:0]           out_op;
    logic                      out_err;
    logic [CNT_W-1:0]          txn_count;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    logic                      out_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    logic_gate_pipe #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_op    (out_op),
        .out_err   (out_err),
        .txn_count (txn_count)
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom);
            in_data  = $urandom;
            in_op    = 3'($urandom);
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        n_checks++;
        if (txn_count !== 16'd0) begin n_fail++; $display("FAIL reset_txn_count: got %0d want 0", txn_count); end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        exp_cnt = '0;
        tick();
    endtask

    // Each vector: op, packed channels {ch3,ch2,ch1,ch0}, expected result, expected err
    task automatic test_all_ops();
        logic [OP_W-1:0] ops  [8];
        logic [31:0]     dat  [8];
        logic [7:0]      exp  [8];
        logic            eerr [8];
        ops[0] = OP_AND;     dat[0] = 32'hFC3CF0FF; exp[0] = 8'h30; eerr[0] = 1'b0;
        ops[1] = OP_NAND;    dat[1] = 32'hFC3CF0FF; exp[1] = 8'hCF; eerr[1] = 1'b0;
        ops[2] = OP_OR;      dat[2] = 32'h08040201; exp[2] = 8'h0F; eerr[2] = 1'b0;
        ops[3] = OP_NOR;     dat[3] = 32'h08040201; exp[3] = 8'hF0; eerr[3] = 1'b0;
        ops[4] = OP_XOR;     dat[4] = 32'h00FF55AA; exp[4] = 8'h00; eerr[4] = 1'b0;
        ops[5] = OP_XNOR;    dat[5] = 32'h00FF55AA; exp[5] = 8'hFF; eerr[5] = 1'b0;
        ops[6] = OP_PASS;    dat[6] = 32'h123456A5; exp[6] = 8'hA5; eerr[6] = 1'b0;
        ops[7] = OP_ILLEGAL; dat[7] = 32'hFFFFFFFF; exp[7] = 8'h00; eerr[7] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_op    = ops[i];
            in_data  = dat[i];
            tick();
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL op%0d_early: out_valid %b after 1 cycle, want 0", i, out_valid); end
            tick();
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL op%0d_latency: out_valid %b after 2 cycles, want 1", i, out_valid); end
            n_checks++;
            if (out_data !== exp[i]) begin n_fail++; $display("FAIL op%0d_data: got %h want %h", i, out_data, exp[i]); end
            n_checks++;
            if (out_err !== eerr[i]) begin n_fail++; $display("FAIL op%0d_err: got %b want %b", i, out_err, eerr[i]); end
            n_checks++;
            if (out_op !== ops[i]) begin n_fail++; $display("FAIL op%0d_op: got %0d want %0d", i, out_op, ops[i]); end
            tick();
            exp_cnt++;
            n_checks++;
            if (txn_count !== exp_cnt) begin n_fail++; $display("FAIL op%0d_count: got %0d want %0d", i, txn_count, exp_cnt); end
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL op%0d_drain: out_valid %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]      exp_q [$];
        logic [OP_W-1:0] op_q  [$];
        logic [7:0]      v;
        logic [7:0]      held;
        logic [7:0]      e;
        logic [OP_W-1:0] eo;
        logic            prev_stall;
        logic            exp_rdy;
        logic            saw_full;
        int wr, rd, occ;
        wr = 0; rd = 0; occ = 0;
        prev_stall = 1'b0; saw_full = 1'b0; held = '0;
        for (int t = 0; t < 60 && rd < 10; t++) begin
            out_ready = !(t >= 4 && t < 9);
            if (wr < 10) begin
                v        = 8'h10 + 8'(wr);
                in_valid = 1'b1;
                if (wr % 2 == 1) begin
                    in_op   = OP_OR;
                    in_data = {8'h00, 8'h00, 8'h00, v};
                end else begin
                    in_op   = OP_PASS;
                    in_data = {8'h5A, 8'hC3, 8'h99, v};
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            exp_rdy = (occ < 2) || out_ready;
            n_checks++;
            if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_in_ready t=%0d: got %b want %b (occ %0d)", t, in_ready, exp_rdy, occ); end
            if (occ == 2 && !out_ready) saw_full = 1'b1;
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    n_fail++;
                    $display("FAIL bp_hold t=%0d: valid %b data %h want valid 1 data %h", t, out_valid, out_data, held);
                end
            end
            prev_stall = out_valid && !out_ready;
            held       = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data[7:0]);
                op_q.push_back(in_op);
                wr++;
                occ++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra t=%0d: unexpected word %h want none", t, out_data);
                end else begin
                    e  = exp_q.pop_front();
                    eo = op_q.pop_front();
                    if (out_data !== e || out_op !== eo) begin
                        n_fail++;
                        $display("FAIL bp_word%0d: got %h/op%0d want %h/op%0d", rd, out_data, out_op, e, eo);
                    end
                end
                rd++;
                occ--;
                exp_cnt++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (rd != 10) begin n_fail++; $display("FAIL bp_timeout: got %0d words want 10", rd); end
        n_checks++;
        if (!saw_full) begin n_fail++; $display("FAIL bp_never_full: got 0 full-stall cycles want >0"); end
        tick();
        n_checks++;
        if (txn_count !== exp_cnt) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", txn_count, exp_cnt); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_AND;
        in_data   = 32'hFFFFFFFF;
        tick();
        in_data   = 32'h0F0F0F0F;
        tick();
        in_valid  = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_preload: valid %b ready %b want valid 1 ready 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
        n_checks++;
        if (txn_count !== 16'd0) begin n_fail++; $display("FAIL mid_async_count: got %0d want 0", txn_count); end
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        exp_cnt   = '0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || txn_count !== 16'd0) begin
                n_fail++;
                $display("FAIL mid_ghost%0d: valid %b count %0d want 0/0", i, out_valid, txn_count);
            end
        end
    endtask

    task automatic test_wrap();
        int acc, cyc;
        acc = 0; cyc = 0;
        out_ready = 1'b1;
        in_op     = OP_XOR;
        in_data   = 32'h01020408;
        in_valid  = 1'b1;
        while (acc < 65535 && cyc < 65600) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            cyc++;
            @(posedge clk);
            #1;
            if (acc == 65535) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc != 65535 || cyc != 65535) begin
            n_fail++;
            $display("FAIL wrap_rate: got %0d words in %0d cycles want 65535 in 65535", acc, cyc);
        end
        tick(); tick(); tick();
        n_checks++;
        if (txn_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max: got %h want ffff", txn_count); end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (txn_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 0000", txn_count); end
    endtask

`ifdef LOGIC_GATE_PIPE_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = OP_AND;
        in_data   = 32'hFC3CF0FF;
        tick();
        in_op     = OP_PASS;
        in_data   = 32'h00000031;
        tick();
        in_valid  = 1'b0;
        n_checks++;
        if (out_data !== 8'h30 || out_parity !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_even: data %h parity %b want 30/0", out_data, out_parity);
        end
        tick();
        n_checks++;
        if (out_data !== 8'h31 || out_parity !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_odd: data %h parity %b want 31/1", out_data, out_parity);
        end
        tick();
    endtask
`endif

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        test_reset();
        test_all_ops();
        test_backpressure();
        test_reset_midstream();
        test_wrap();
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
